cl_write: RTL

CL_WRITE -- requirements
Module: cl_write

---
 rtl/cl_write.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cl_write.sv
// Code-length-code table writer: deserialises LEN_BIT-wide fields and writes them to BRAM in PERM order.
// Latency: each write lands the cycle after the last bit of its field is accepted (>= LEN_BIT+1 cycles per entry).
// Backpressure: bit_ready drops during write/clear/done cycles; bit_valid gaps stall without loss. Optional CLEAR_UNUSED_EN zero-fills unsupplied entries.
module cl_write #(
    parameter int LEN_BIT     = 3,
    parameter int INDEX_BIT   = 4,
    parameter int LEN_ADDRESS = 6,
    parameter int INDEX_COUNT = 19
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [3:0]                   hclen,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    output logic                         bit_ready,
    output logic [LEN_ADDRESS-1:0]       add,
    output logic                         ena,
    output logic                         wea,
    output logic [LEN_BIT+INDEX_BIT-1:0] dout,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    // Entry index and entry count both fit in 5 bits (table holds at most 19 entries).
    localparam int IDX_W = 5;
    localparam int BC_W  = $clog2(LEN_BIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef CLEAR_UNUSED_EN
        S_CLEAR,
`endif
        S_DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   n;
    logic [BC_W-1:0]    bcnt;
    logic [LEN_BIT-1:0] len_q;

    logic [LEN_BIT-1:0] len_next;
    logic [IDX_W-1:0]   idx_nxt;
    logic [IDX_W-1:0]   perm_cur;
    logic [IDX_W-1:0]   perm_nxt;
    logic               fire;
    logic               last_bit;
    logic               in_build;

    // Order in which code-length-code entries arrive in the stream.
    function automatic logic [IDX_W-1:0] perm(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] p;
        case (i)
            5'd0:    p = 5'd16;
            5'd1:    p = 5'd17;
            5'd2:    p = 5'd18;
            5'd3:    p = 5'd0;
            5'd4:    p = 5'd8;
            5'd5:    p = 5'd7;
            5'd6:    p = 5'd9;
            5'd7:    p = 5'd6;
            5'd8:    p = 5'd10;
            5'd9:    p = 5'd5;
            5'd10:   p = 5'd11;
            5'd11:   p = 5'd4;
            5'd12:   p = 5'd12;
            5'd13:   p = 5'd3;
            5'd14:   p = 5'd13;
            5'd15:   p = 5'd2;
            5'd16:   p = 5'd14;
            5'd17:   p = 5'd1;
            5'd18:   p = 5'd15;
            default: p = 5'd0;
        endcase
        return p;
    endfunction

    // Field value including the bit arriving this cycle, next entry index and lookups.
    always_comb begin
        len_next       = len_q;
        len_next[bcnt] = bit_in;
        idx_nxt        = idx + 5'd1;
        perm_cur       = perm(idx);
        perm_nxt       = perm(idx_nxt);
        fire           = bit_valid & bit_ready;
        last_bit       = (bcnt == BC_W'(LEN_BIT - 1));
        in_build       = (state == S_RECV) || (state == S_WRITE)
`ifdef CLEAR_UNUSED_EN
                         || (state == S_CLEAR)
`endif
                         ;
    end

    // Build sequencer with registered BRAM port and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            n         <= '0;
            bcnt      <= '0;
            len_q     <= '0;
            add       <= '0;
            ena       <= 1'b0;
            wea       <= 1'b0;
            dout      <= '0;
            bit_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // A start that arrives mid-build (including the final write) is a protocol error.
            if (start && in_build)
                error <= 1'b1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n         <= {1'b0, hclen} + 5'd4;
                        idx       <= '0;
                        bcnt      <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        bit_ready <= 1'b1;
                        state     <= S_RECV;
                    end
                end

                S_RECV: begin
                    if (fire) begin
                        len_q <= len_next;
                        if (last_bit) begin
                            bcnt      <= '0;
                            bit_ready <= 1'b0;
                            ena       <= 1'b1;
                            wea       <= 1'b1;
                            add       <= LEN_ADDRESS'(perm_cur);
                            dout      <= {perm_cur[INDEX_BIT-1:0], len_next};
                            state     <= S_WRITE;
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
                end

                S_WRITE: begin
                    ena <= 1'b0;
                    wea <= 1'b0;
                    if (idx_nxt < n) begin
                        idx       <= idx_nxt;
                        bit_ready <= 1'b1;
                        state     <= S_RECV;
                    end
`ifdef CLEAR_UNUSED_EN
                    else if (idx_nxt < IDX_W'(INDEX_COUNT)) begin
                        // First zero-fill write goes out in the very next cycle.
                        idx   <= idx_nxt;
                        ena   <= 1'b1;
                        wea   <= 1'b1;
                        add   <= LEN_ADDRESS'(perm_nxt);
                        dout  <= {perm_nxt[INDEX_BIT-1:0], {LEN_BIT{1'b0}}};
                        state <= S_CLEAR;
                    end
`endif
                    else begin
                        // Index stays on the last entry so it never runs past the table.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

`ifdef CLEAR_UNUSED_EN
                S_CLEAR: begin
                    if (idx_nxt < IDX_W'(INDEX_COUNT)) begin
                        idx  <= idx_nxt;
                        add  <= LEN_ADDRESS'(perm_nxt);
                        dout <= {perm_nxt[INDEX_BIT-1:0], {LEN_BIT{1'b0}}};
                    end else begin
                        ena   <= 1'b0;
                        wea   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
